// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the writeback stage: writeback source select,
// load opcode and funct3 encodings, and default datapath sizes.
package riscv_pkg;

    localparam int unsigned XLEN_DEFAULT      = 32;
    localparam int unsigned REG_COUNT_DEFAULT = 32;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_RSV = 2'd3
    } wb_sel_e;

    localparam logic [6:0] OPC_LOAD = 7'b0000011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Picks the addressed byte/halfword out of an aligned load word and sign- or
// zero-extends it according to funct3; full words pass through.
module load_extend
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] mem_i,
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    output logic [XLEN-1:0] ext_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Halfword select ignores offset[0]: misaligned halves are not trapped here.
    assign byte_v = mem_i[{offset, 3'b000} +: 8];
    assign half_v = mem_i[{offset[1], 4'b0000} +: 16];

    always_comb begin
        ext_data = mem_i;
        case (funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_v[7]}}, byte_v};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_v};
            F3_LH:   ext_data = {{(XLEN-16){half_v[15]}}, half_v};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_v};
            default: ext_data = mem_i;
        endcase
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Writeback stage: selects the writeback value, commits it to the integer register
// file, serves two ID read ports with optional same-cycle bypass, counts retirements.
module wb_stage_regfile
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN         = XLEN_DEFAULT,
    parameter int unsigned REG_COUNT    = REG_COUNT_DEFAULT,
    parameter bit          WRITE_BYPASS = 1'b1,
    parameter int unsigned CNT_W        = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  mem_i,
    input  logic [XLEN-1:0]  pc_plus_four_i,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  alu_out_i,
    input  logic [1:0]       wb_sel_i,
    input  logic             regWEn_i,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic [4:0]       wb_rd_o,
    output logic             wb_en_o,
    output logic [CNT_W-1:0] instret_o
);

    logic [XLEN-1:0]  regs [REG_COUNT];
    logic [CNT_W-1:0] instret_q;
    logic [XLEN-1:0]  load_data;

    load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .mem_i    (mem_i),
        .funct3   (inst_i[14:12]),
        .offset   (alu_out_i[1:0]),
        .ext_data (load_data)
    );

    assign wb_rd_o   = inst_i[11:7];
    assign wb_en_o   = regWEn_i && (wb_rd_o != 5'd0);
    assign instret_o = instret_q;

    always_comb begin
        wb_data_o = alu_out_i;
        case (wb_sel_e'(wb_sel_i))
            WB_MEM:  wb_data_o = load_data;
            WB_PC4:  wb_data_o = pc_plus_four_i;
            default: wb_data_o = alu_out_i;
        endcase
    end

    // Only the bypass compare touches the writeback path; the array read stays direct.
    function automatic logic [XLEN-1:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0) begin
            return '0;
        end else if (WRITE_BYPASS && wb_en_o && (addr == wb_rd_o)) begin
            return wb_data_o;
        end else begin
            return regs[addr];
        end
    endfunction

    always_comb begin
        rs1_data_o = read_port(rs1_addr_i);
        rs2_data_o = read_port(rs2_addr_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(REG_COUNT); i++) begin
                regs[i] <= '0;
            end
            instret_q <= '0;
        end else begin
            if (wb_en_o) begin
                regs[wb_rd_o] <= wb_data_o;
            end
            if (inst_i != 32'd0) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed and random checks of wb_stage_regfile against an architectural model
// of the register file, load extension and retirement counter.
module tb_wb_stage_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_i, pc_plus_four_i, inst_i, alu_out_i;
    logic [1:0]  wb_sel_i;
    logic        regWEn_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i;
    logic [31:0] rs1_data_o, rs2_data_o, wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_en_o;
    logic [63:0] instret_o;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_regs [32];
    logic [63:0] model_cnt;

    always #5 clk = ~clk;

    wb_stage_regfile dut (
        .clk            (clk),
        .reset          (reset),
        .mem_i          (mem_i),
        .pc_plus_four_i (pc_plus_four_i),
        .inst_i         (inst_i),
        .alu_out_i      (alu_out_i),
        .wb_sel_i       (wb_sel_i),
        .regWEn_i       (regWEn_i),
        .rs1_addr_i     (rs1_addr_i),
        .rs2_addr_i     (rs2_addr_i),
        .rs1_data_o     (rs1_data_o),
        .rs2_data_o     (rs2_data_o),
        .wb_data_o      (wb_data_o),
        .wb_rd_o        (wb_rd_o),
        .wb_en_o        (wb_en_o),
        .instret_o      (instret_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
        logic [31:0] r;
        r = $urandom;
        return {r[31:15], f3, rd, 7'b0000011};
    endfunction

    // Reference load value from arithmetic on the raw word.
    function automatic logic [31:0] ref_load();
        int unsigned off, b, h;
        off = int'(alu_out_i[1:0]);
        b = (mem_i >> (8 * off)) % 256;
        h = (mem_i >> (16 * (off / 2))) % 65536;
        case (inst_i[14:12])
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return mem_i;
        endcase
    endfunction

    function automatic logic [31:0] ref_wb();
        if (wb_sel_i == 2'd1) return ref_load();
        if (wb_sel_i == 2'd2) return pc_plus_four_i;
        return alu_out_i;
    endfunction

    function automatic logic ref_en();
        return regWEn_i && (inst_i[11:7] != 5'd0);
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ref_en() && a == inst_i[11:7]) return ref_wb();
        return model_regs[a];
    endfunction

    task automatic check_outputs();
        chk("rs1_data", rs1_data_o, ref_read(rs1_addr_i));
        chk("rs2_data", rs2_data_o, ref_read(rs2_addr_i));
        chk("wb_data", wb_data_o, ref_wb());
        chk("wb_rd", wb_rd_o, inst_i[11:7]);
        chk("wb_en", wb_en_o, ref_en());
        chk("instret", instret_o, model_cnt);
    endtask

    task automatic drive(input logic rst, input logic [31:0] inst, input logic [1:0] sel,
                         input logic wen, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2);
        reset = rst; inst_i = inst; wb_sel_i = sel; regWEn_i = wen;
        alu_out_i = alu; mem_i = mem; pc_plus_four_i = pc4;
        rs1_addr_i = a1; rs2_addr_i = a2;
        #1;
    endtask

    task automatic commit();
        logic [31:0] v;
        v = ref_wb();
        @(posedge clk);
        if (reset) begin
            foreach (model_regs[i]) model_regs[i] = 32'd0;
            model_cnt = 64'd0;
        end else begin
            if (ref_en()) model_regs[inst_i[11:7]] = v;
            if (inst_i != 32'd0) model_cnt = model_cnt + 64'd1;
        end
        @(negedge clk);
    endtask

    logic [2:0]  ld_f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
    logic [1:0]  ld_off [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] ld_exp [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF,
                                32'h0000_7F01, 32'h80FF_7F01};

    initial begin
        logic [31:0] v, r1, r2;
        logic [4:0]  rd;
        foreach (model_regs[i]) model_regs[i] = 32'd0;
        model_cnt = 64'd0;
        drive(1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        @(negedge clk);

        // Reset with a pending write to x5.
        drive(1'b1, mk_inst(3'b010, 5'd5), 2'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd0, 5'd0, 5'd0);
        commit();
        commit();
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0);
        check_outputs();
        chk("x5_after_reset", rs1_data_o, 32'd0);
        chk("instret_after_reset", instret_o, 64'd0);
        commit();

        // ALU writeback with bypass, then from the array.
        drive(1'b0, mk_inst(3'b000, 5'd3), 2'd0, 1'b1, 32'h1234_5678, 32'd0, 32'd0, 5'd3, 5'd0);
        check_outputs();
        chk("alu_bypass", rs1_data_o, 32'h1234_5678);
        commit();
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd3, 5'd0);
        chk("alu_array", rs1_data_o, 32'h1234_5678);
        commit();

        // Load extension table.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, mk_inst(ld_f3[i], 5'(10 + i)), 2'd1, 1'b1, 32'h0000_1000 | 32'(ld_off[i]),
                  32'h80FF_7F01, 32'd0, 5'(10 + i), 5'd0);
            check_outputs();
            chk($sformatf("load_%0d", i), wb_data_o, ld_exp[i]);
            commit();
        end

        // x0 write is discarded; JAL link value.
        drive(1'b0, mk_inst(3'b000, 5'd0), 2'd0, 1'b1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd0, 5'd0);
        check_outputs();
        chk("x0_wb_en", wb_en_o, 1'b0);
        chk("x0_read", rs1_data_o, 32'd0);
        commit();
        drive(1'b0, {20'h00000, 5'd1, 7'b1101111}, 2'd2, 1'b1, 32'h5555_0000, 32'd0,
              32'h0000_0104, 5'd0, 5'd1);
        check_outputs();
        commit();
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd1, 5'd0);
        chk("jal_link", rs1_data_o, 32'h0000_0104);
        chk("x0_after_write", rs2_data_o, 32'd0);
        commit();

        // Dual bypass on the same register.
        v = $urandom;
        drive(1'b0, mk_inst(3'b010, 5'd7), 2'd3, 1'b1, v, 32'd0, 32'd0, 5'd7, 5'd7);
        check_outputs();
        chk("dual_rs1", rs1_data_o, v);
        chk("dual_rs2", rs2_data_o, v);
        commit();

        // Ten retirements, three bubbles, from a cleared counter.
        drive(1'b1, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        commit();
        for (int i = 0; i < 13; i++) begin
            if (i == 2 || i == 6 || i == 11)
                drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
            else
                drive(1'b0, {25'h1, 7'b0100011}, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
            commit();
        end
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("instret_10", instret_o, 64'd10);

        // Counter wrap.
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret_q;
        model_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("instret_preload", instret_o, 64'hFFFF_FFFF_FFFF_FFFF);
        commit();
        drive(1'b0, {25'h1, 7'b1100011}, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        commit();
        drive(1'b0, 32'd0, 2'd0, 1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("instret_wrap", instret_o, 64'd0);
        commit();

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom);
            r1 = $urandom;
            r2 = $urandom;
            v  = ($urandom_range(0, 7) == 0) ? 32'd0 : mk_inst(3'($urandom), rd);
            drive(($urandom_range(0, 59) == 0), v, 2'($urandom), 1'($urandom), $urandom,
                  $urandom, $urandom,
                  (r1[3:0] == 0) ? v[11:7] : r1[8:4],
                  (r2[3:0] == 0) ? v[11:7] : r2[8:4]);
            check_outputs();
            commit();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
